// File: rtl/apb_soc_initiator.sv
// APB4 initiator: one request at a time, decoded onto the SoC peripheral map.
// Optional ACCESS timeout: define APB_INITIATOR_TIMEOUT_EN.
module apb_soc_initiator #(
  parameter int NUM_SLAVES     = 10,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [31:0]              req_addr_i,
  input  logic                     req_write_i,
  input  logic [31:0]              req_wdata_i,
  input  logic [3:0]               req_wstrb_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [31:0]              rsp_rdata_o,
  output logic                     rsp_err_o,
  output logic [31:0]              paddr_o,
  output logic [31:0]              pwdata_o,
  output logic                     pwrite_o,
  output logic [3:0]               pstrb_o,
  output logic [NUM_SLAVES-1:0]    psel_o,
  output logic                     penable_o,
  input  logic [NUM_SLAVES*32-1:0] prdata_i,
  input  logic [NUM_SLAVES-1:0]    pready_i,
  input  logic [NUM_SLAVES-1:0]    pslverr_i
);

  localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {
    IDLE, SETUP, ACCESS, RESP
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, dec_idx;
  logic          dec_hit;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic [3:0]    strb_q;
  logic          write_q, err_q;
  logic          sel_ready, sel_err, tmo;
  logic [31:0]   sel_rdata;
  logic [19:0]   pg;

  // 4 KiB page decode; UDMA spans pages 0x1A200..0x1A221
  assign pg = req_addr_i[31:12];

  always_comb begin
    dec_hit = 1'b1;
    dec_idx = '0;
    unique case (1'b1)
      (pg == 20'h1A100): dec_idx = IW'(0);
      (pg == 20'h1A101): dec_idx = IW'(1);
      (pg == 20'h1A103): dec_idx = IW'(2);
      (pg == 20'h1A104): dec_idx = IW'(3);
      (pg == 20'h1A105): dec_idx = IW'(4);
      (pg == 20'h1A106): dec_idx = IW'(5);
      (pg == 20'h1A107): dec_idx = IW'(6);
      (pg == 20'h1A108): dec_idx = IW'(7);
      (pg == 20'h1A109): dec_idx = IW'(8);
      (pg >= 20'h1A200 && pg < 20'h1A222):
        dec_idx = IW'(9);
      default: dec_hit = 1'b0;
    endcase
  end

  assign sel_ready = pready_i[idx_q];
  assign sel_err   = pslverr_i[idx_q];
  assign sel_rdata = prdata_i[idx_q*32 +: 32];

`ifdef APB_INITIATOR_TIMEOUT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (state_q == SETUP) begin
      cnt_q <= '0;
    end else if (state_q == ACCESS && !sel_ready) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // pready in the limit cycle still completes normally
  assign tmo = (state_q == ACCESS) && !sel_ready &&
               (cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (req_valid_i)
          state_d = dec_hit ? SETUP : RESP;
      SETUP:
        state_d = ACCESS;
      ACCESS:
        if (sel_ready || tmo)
          state_d = RESP;
      RESP:
        if (rsp_ready_i)
          state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid_i) begin
        idx_q   <= dec_idx;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        strb_q  <= req_write_i ? req_wstrb_i : 4'h0;
        write_q <= req_write_i;
        rdata_q <= '0;
        err_q   <= !dec_hit;
      end
      if (state_q == ACCESS) begin
        if (sel_ready) begin
          err_q   <= sel_err;
          rdata_q <= (write_q || sel_err) ? 32'h0 : sel_rdata;
        end else if (tmo) begin
          err_q   <= 1'b1;
          rdata_q <= '0;
        end
      end
    end
  end

  always_comb begin
    psel_o = '0;
    for (int k = 0; k < NUM_SLAVES; k++)
      psel_o[k] = (state_q == SETUP || state_q == ACCESS) &&
                  (idx_q == IW'(k));
  end

  assign penable_o   = (state_q == ACCESS);
  assign req_ready_o = (state_q == IDLE) && !rst_i;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign paddr_o     = addr_q;
  assign pwdata_o    = wdata_q;
  assign pwrite_o    = write_q;
  assign pstrb_o     = strb_q;

endmodule

// File: tb/tb_apb_soc_initiator.sv
// Directed bench for apb_soc_initiator: decode, wait states, errors,
// response stall, reset abort and (if enabled) ACCESS timeout.
module tb_apb_soc_initiator;

  localparam int NS = 10;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [31:0]   req_addr_i;
  logic          req_write_i;
  logic [31:0]   req_wdata_i;
  logic [3:0]    req_wstrb_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [31:0]   rsp_rdata_o;
  logic          rsp_err_o;
  logic [31:0]   paddr_o;
  logic [31:0]   pwdata_o;
  logic          pwrite_o;
  logic [3:0]    pstrb_o;
  logic [NS-1:0] psel_o;
  logic          penable_o;
  logic [NS*32-1:0] prdata_i;
  logic [NS-1:0] pready_i;
  logic [NS-1:0] pslverr_i;

  int errors = 0;
  int checks = 0;

  apb_soc_initiator #(
    .NUM_SLAVES(NS),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_write_i(req_write_i),
    .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o),
    .pwrite_o(pwrite_o), .pstrb_o(pstrb_o),
    .psel_o(psel_o), .penable_o(penable_o),
    .prdata_i(prdata_i), .pready_i(pready_i),
    .pslverr_i(pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Called at posedge+1; slv < 0 means a decode miss is expected.
  task automatic xfer(input string tg, input logic [31:0] a,
                      input logic w, input logic [31:0] wd,
                      input logic [3:0] ws, input int slv,
                      input int waits, input logic [31:0] rd,
                      input logic serr, input int hold,
                      input logic [31:0] exp_rd, input logic exp_err);
    logic [NS-1:0] sel;
    sel = '0;
    req_valid_i = 1'b1;
    req_addr_i  = a;
    req_write_i = w;
    req_wdata_i = wd;
    req_wstrb_i = ws;
    pready_i    = '0;
    pslverr_i   = '0;
    if (slv >= 0) begin
      sel[slv] = 1'b1;
      prdata_i[slv*32 +: 32] = rd;
      pslverr_i[slv] = serr;
    end
    check({tg, "_rdy"}, req_ready_o, 1'b1);
    tick();
    req_valid_i = 1'b0;
    if (slv >= 0) begin
      check({tg, "_setup_sel"}, psel_o, sel);
      check({tg, "_setup_pen"}, penable_o, 1'b0);
      check({tg, "_paddr"}, paddr_o, a);
      check({tg, "_pwrite"}, pwrite_o, w);
      check({tg, "_pstrb"}, pstrb_o, w ? ws : 4'h0);
      if (w) check({tg, "_pwdata"}, pwdata_o, wd);
      check({tg, "_setup_busy"}, req_ready_o, 1'b0);
      tick();
      for (int i = 0; i <= waits; i++) begin
        if (i == waits) pready_i[slv] = 1'b1;
        check({tg, "_acc_sel"}, psel_o, sel);
        check({tg, "_acc_pen"}, penable_o, 1'b1);
        check({tg, "_acc_paddr"}, paddr_o, a);
        check({tg, "_acc_vld"}, rsp_valid_o, 1'b0);
        tick();
      end
      pready_i = '0;
    end
    for (int h = 0; h <= hold; h++) begin
      check({tg, "_rsp_vld"}, rsp_valid_o, 1'b1);
      check({tg, "_rsp_rdata"}, rsp_rdata_o, exp_rd);
      check({tg, "_rsp_err"}, rsp_err_o, exp_err);
      check({tg, "_rsp_sel"}, psel_o, '0);
      check({tg, "_rsp_pen"}, penable_o, 1'b0);
      check({tg, "_rsp_rdy"}, req_ready_o, 1'b0);
      if (h == hold) rsp_ready_i = 1'b1;
      tick();
    end
    rsp_ready_i = 1'b0;
    check({tg, "_done_vld"}, rsp_valid_o, 1'b0);
    check({tg, "_done_rdy"}, req_ready_o, 1'b1);
  endtask

  initial begin
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_write_i = 1'b0;
    req_wdata_i = '0;
    req_wstrb_i = '0;
    rsp_ready_i = 1'b0;
    prdata_i    = '0;
    pready_i    = '0;
    pslverr_i   = '0;
    #3;
    check("rst_rdy", req_ready_o, 1'b0);
    check("rst_vld", rsp_valid_o, 1'b0);
    check("rst_sel", psel_o, '0);
    check("rst_pen", penable_o, 1'b0);
    check("rst_paddr", paddr_o, 32'h0);
    check("rst_rdata", rsp_rdata_o, 32'h0);
    check("rst_err", rsp_err_o, 1'b0);
    tick();
    tick();
    rst_i = 1'b0;
    tick();

    xfer("gpio_rd", 32'h1A10_5004, 1'b0, 32'h0, 4'hF, 4, 0,
         32'hDEAD_BEEF, 1'b0, 0, 32'hDEAD_BEEF, 1'b0);
    xfer("udma_wr", 32'h1A22_1FFC, 1'b1, 32'h1234_5678, 4'hF, 9, 3,
         32'hAAAA_5555, 1'b0, 0, 32'h0, 1'b0);
    xfer("miss_gap", 32'h1A10_2000, 1'b0, 32'h0, 4'h0, -1, 0,
         32'h0, 1'b0, 0, 32'h0, 1'b1);
    xfer("miss_udma", 32'h1A22_2000, 1'b0, 32'h0, 4'h0, -1, 0,
         32'h0, 1'b0, 0, 32'h0, 1'b1);
    xfer("miss_a000", 32'h1A10_A000, 1'b0, 32'h0, 4'h0, -1, 0,
         32'h0, 1'b0, 0, 32'h0, 1'b1);
    xfer("can1_err", 32'h1A10_9010, 1'b0, 32'h0, 4'h0, 8, 0,
         32'hFFFF_FFFF, 1'b1, 5, 32'h0, 1'b1);
    xfer("adv_wr", 32'h1A10_3FFC, 1'b1, 32'hCAFE_0001, 4'h3, 2, 1,
         32'h5555_5555, 1'b0, 1, 32'h0, 1'b0);
    xfer("udma_lo", 32'h1A20_0000, 1'b0, 32'h0, 4'h0, 9, 0,
         32'h0BAD_F00D, 1'b0, 0, 32'h0BAD_F00D, 1'b0);

`ifdef APB_INITIATOR_TIMEOUT_EN
    req_valid_i = 1'b1;
    req_addr_i  = 32'h1A10_5000;
    req_write_i = 1'b0;
    pready_i    = '0;
    pslverr_i   = '0;
    tick();
    req_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("to_pen", penable_o, 1'b1);
    end
    tick();
    check("to_sel", psel_o, '0);
    check("to_vld", rsp_valid_o, 1'b1);
    check("to_err", rsp_err_o, 1'b1);
    check("to_rdata", rsp_rdata_o, 32'h0);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    xfer("to_edge", 32'h1A10_5008, 1'b0, 32'h0, 4'h0, 4, 3,
         32'h0000_1234, 1'b0, 0, 32'h0000_1234, 1'b0);
`endif

    // reset while in ACCESS
    req_valid_i = 1'b1;
    req_addr_i  = 32'h1A10_5000;
    req_write_i = 1'b0;
    pready_i    = '0;
    tick();
    req_valid_i = 1'b0;
    tick();
    check("ra_pen_pre", penable_o, 1'b1);
    #2;
    rst_i = 1'b1;
    #1;
    check("ra_sel", psel_o, '0);
    check("ra_pen", penable_o, 1'b0);
    check("ra_vld", rsp_valid_o, 1'b0);
    check("ra_rdy", req_ready_o, 1'b0);
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("ra_novld", rsp_valid_o, 1'b0);
      tick();
    end
    xfer("fll_rd", 32'h1A10_0000, 1'b0, 32'h0, 4'h0, 0, 0,
         32'h0000_00A5, 1'b0, 0, 32'h0000_00A5, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
